// File: rtl/match_event_log.sv
// match_event_log: logs detector match pulses as event words in a small FIFO, with a
// saturating match count and sticky overflow. Define MATCH_TS_EN for cycle-timestamp words.
module match_event_log #(
   parameter int DEPTH = 4,
   parameter int TS_W  = 16,
   parameter int CNT_W = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   match,
   input  logic                   clr,
   input  logic                   rd_ready,
   output logic                   rd_valid,
   output logic [TS_W-1:0]        rd_data,
   output logic [$clog2(DEPTH):0] level,
   output logic [CNT_W-1:0]       match_cnt,
   output logic                   overflow
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = PTR_W + 1;
   localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

   typedef enum logic [1:0] {OCC_EMPTY, OCC_PARTIAL, OCC_FULL} occ_t;

   occ_t             occ_state;
   logic [TS_W-1:0]  mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [TS_W-1:0]  src;
   logic             pop;
   logic             push;
   logic             drop;

   always_comb begin
      occ_state = OCC_PARTIAL;
      if (level == '0)
         occ_state = OCC_EMPTY;
      else if (level == FULL_LVL)
         occ_state = OCC_FULL;
   end

   // Read port: the head word transfers on any edge where rd_valid and rd_ready are both high;
   // while rd_valid is high and rd_ready low, rd_valid and rd_data hold steady.
   assign rd_valid = (occ_state != OCC_EMPTY);
   assign rd_data  = rd_valid ? mem[rd_ptr] : '0;

   assign pop  = rd_valid && rd_ready && !clr;
   assign push = match && !clr && ((occ_state != OCC_FULL) || pop);
   assign drop = match && !clr && (occ_state == OCC_FULL) && !pop;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         level     <= '0;
         match_cnt <= '0;
         overflow  <= 1'b0;
         src       <= '0;
      end else if (clr) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         level     <= '0;
         match_cnt <= '0;
         overflow  <= 1'b0;
         src       <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop)
            level <= level + 1'b1;
         else if (pop && !push)
            level <= level - 1'b1;
         if (drop)
            overflow <= 1'b1;
         if (match && (match_cnt != '1))
            match_cnt <= match_cnt + 1'b1;
`ifdef MATCH_TS_EN
         src <= src + 1'b1;
`else
         // Dropped matches still consume a sequence number, so gaps reveal losses.
         if (match)
            src <= src + 1'b1;
`endif
      end
   end

   // Storage needs no reset: rd_data is masked to zero whenever the FIFO is empty.
   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= src;
   end

endmodule

// File: tb/tb_match_event_log.sv
// Bench for match_event_log: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_match_event_log;
   localparam int DEPTH   = 4;
   localparam int TS_W    = 16;
   localparam int CNT_W   = 3;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic                   clk;
   logic                   reset;
   logic                   match;
   logic                   clr;
   logic                   rd_ready;
   logic                   rd_valid;
   logic [TS_W-1:0]        rd_data;
   logic [$clog2(DEPTH):0] level;
   logic [CNT_W-1:0]       match_cnt;
   logic                   overflow;

   match_event_log #(.DEPTH(DEPTH), .TS_W(TS_W), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .reset     (reset),
      .match     (match),
      .clr       (clr),
      .rd_ready  (rd_ready),
      .rd_valid  (rd_valid),
      .rd_data   (rd_data),
      .level     (level),
      .match_cnt (match_cnt),
      .overflow  (overflow)
   );

   // clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // reference model state
   logic [TS_W-1:0] exp_q[$];
   int              m_cnt;
   bit              m_ovf;
   logic [TS_W-1:0] m_src;

   int checks;
   int errors;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at time %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      exp_q.delete();
      m_cnt = 0;
      m_ovf = 1'b0;
      m_src = '0;
   endtask

   // Applies the rules for one rising edge using the inputs sampled there.
   task automatic model_update();
      bit popped;
      bit accept;
      if (clr) begin
         model_reset();
      end else begin
         popped = (exp_q.size() != 0) && rd_ready;
         accept = match && ((exp_q.size() < DEPTH) || popped);
         if (popped)
            void'(exp_q.pop_front());
         if (accept)
            exp_q.push_back(m_src);
         if (match && !accept)
            m_ovf = 1'b1;
         if (match && (m_cnt < CNT_MAX))
            m_cnt++;
`ifdef MATCH_TS_EN
         m_src = m_src + 1'b1;
`else
         if (match)
            m_src = m_src + 1'b1;
`endif
      end
   endtask

   task automatic compare_model();
      check("rd_valid",  32'(rd_valid),  32'(exp_q.size() != 0));
      check("rd_data",   32'(rd_data),   (exp_q.size() != 0) ? 32'(exp_q[0]) : 32'd0);
      check("level",     32'(level),     32'(exp_q.size()));
      check("match_cnt", 32'(match_cnt), 32'(m_cnt));
      check("overflow",  32'(overflow),  32'(m_ovf));
   endtask

   // driver: apply inputs, advance one edge, check at the following falling edge
   task automatic step(input bit m, input bit c, input bit r);
      match    = m;
      clr      = c;
      rd_ready = r;
      @(posedge clk);
      model_update();
      @(negedge clk);
      compare_model();
   endtask

   initial begin
      int bias;
      checks   = 0;
      errors   = 0;
      reset    = 1'b0;
      match    = 1'b0;
      clr      = 1'b0;
      rd_ready = 1'b0;
      model_reset();

      // reset state
      repeat (2) @(negedge clk);
      check("rst_valid", 32'(rd_valid), 0);
      check("rst_data",  32'(rd_data), 0);
      check("rst_level", 32'(level), 0);
      check("rst_cnt",   32'(match_cnt), 0);
      check("rst_ovf",   32'(overflow), 0);
      #2 reset = 1'b1;

      // fill and overflow: six back-to-back matches from the first edge after release
      repeat (6) step(1, 0, 0);
      check("fill_level", 32'(level), 4);
      check("fill_ovf",   32'(overflow), 1);
      check("fill_cnt",   32'(match_cnt), 6);
      for (int i = 0; i < 4; i++) begin
         check("fill_order", 32'(rd_data), 32'(i));
         step(0, 0, 1);
      end
      check("drain_level", 32'(level), 0);
      check("drain_valid", 32'(rd_valid), 0);
      check("drain_data",  32'(rd_data), 0);

      // later match: sequence number 6, or timestamp 10 (edge index since release)
      step(1, 0, 0);
`ifdef MATCH_TS_EN
      check("late_word", 32'(rd_data), 10);
`else
      check("late_word", 32'(rd_data), 6);
`endif
      check("late_level", 32'(level), 1);
      check("sat_cnt",    32'(match_cnt), 7);
      step(0, 0, 1);
      check("pop_valid", 32'(rd_valid), 0);
      check("pop_data",  32'(rd_data), 0);
      check("sat_hold",  32'(match_cnt), 7);

      // full with simultaneous push and pop
      step(0, 1, 0);
      check("clr_cnt", 32'(match_cnt), 0);
      repeat (4) step(1, 0, 0);
      step(1, 0, 1);
      check("pp_level", 32'(level), 4);
      check("pp_ovf",   32'(overflow), 0);
      for (int i = 1; i <= 4; i++) begin
         check("pp_order", 32'(rd_data), 32'(i));
         step(0, 0, 1);
      end

      // clr priority over match and pop
      repeat (5) step(1, 0, 0);
      step(0, 0, 1);
      check("pre_clr_level", 32'(level), 3);
      check("pre_clr_ovf",   32'(overflow), 1);
      step(1, 1, 1);
      check("clr_level", 32'(level), 0);
      check("clr_valid", 32'(rd_valid), 0);
      check("clr_cnt2",  32'(match_cnt), 0);
      check("clr_ovf",   32'(overflow), 0);
      step(1, 0, 0);
      check("post_clr_word", 32'(rd_data), 0);
      check("post_clr_cnt",  32'(match_cnt), 1);

      // asynchronous reset between edges
      step(1, 0, 0);
      check("pre_rst_level", 32'(level), 2);
      #2 reset = 1'b0;
      #1;
      check("arst_valid", 32'(rd_valid), 0);
      check("arst_data",  32'(rd_data), 0);
      check("arst_level", 32'(level), 0);
      check("arst_cnt",   32'(match_cnt), 0);
      check("arst_ovf",   32'(overflow), 0);
      model_reset();
      #1 reset = 1'b1;

      // randomized traffic with a drain bias that changes every 200 cycles
      bias = 50;
      for (int n = 0; n < 3000; n++) begin
         if ((n % 200) == 0)
            bias = $urandom_range(10, 90);
         step($urandom_range(0, 99) < 55,
              $urandom_range(0, 99) < 2,
              $urandom_range(0, 99) < bias);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
